// File: rtl/seg7_frame_display_if.sv
// Bundle of source/select inputs and segment/status outputs for seg7_frame_display.
interface seg7_frame_display_if #(
  parameter int NUM_SRC    = 4,
  parameter int NUM_FIELDS = 3,
  parameter int FIELD_W    = 8,
  parameter int SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
  logic [NUM_SRC*NUM_FIELDS*FIELD_W-1:0] src_data;
  logic [SEL_W-1:0]                      sel;
  logic [NUM_FIELDS-1:0]                 edit_mask;
  logic [NUM_FIELDS*14-1:0]              seg;
  logic                                  busy;
  logic                                  frame_done;

  modport master (
    output src_data, sel, edit_mask,
    input  seg, busy, frame_done
  );

  modport slave (
    input  src_data, sel, edit_mask,
    output seg, busy, frame_done
  );
endinterface

// File: rtl/seg7_frame_display.sv
// Multi-field 7-segment frame display: source select, serial double-dabble BCD, blink, frame strobe.
// Optional LEADING_ZERO_BLANK_EN blanks a zero tens digit in the most significant field.
module seg7_frame_display #(
  parameter int NUM_SRC    = 4,
  parameter int NUM_FIELDS = 3,
  parameter int FIELD_W    = 8,
  parameter int BLINK_DIV  = 25000000,
  parameter int SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input logic            clock,
  input logic            reset,
  seg7_frame_display_if.slave bus
);

  localparam int FRAME_W = NUM_FIELDS * FIELD_W;
  localparam int SEG_W   = NUM_FIELDS * 14;
  localparam int FI_W    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int BC_W    = $clog2(FIELD_W);
  localparam int BD_W    = $clog2(BLINK_DIV);

  localparam logic [6:0] GLYPH_DASH = 7'h3F;
  localparam logic [6:0] GLYPH_OFF  = 7'h7F;

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = GLYPH_OFF;
    endcase
  endfunction

  function automatic logic [7:0] dabble_step(input logic [7:0] b, input logic din);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = b[3:0];
    hi = b[7:4];
    if (lo >= 4'd5) lo = lo + 4'd3;
    if (hi >= 4'd5) hi = hi + 4'd3;
    dabble_step = {hi[2:0], lo, din};
  endfunction

  state_t             state;
  logic [FRAME_W-1:0] snap;
  logic               sel_bad;
  logic [FI_W-1:0]    fidx;
  logic [BC_W-1:0]    bitcnt;
  logic [7:0]         bcd;
  logic [SEG_W-1:0]   shadow;
  logic [SEG_W-1:0]   seg_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [FRAME_W-1:0] picked;
  logic               sel_hit;
  logic [FIELD_W-1:0] cur_field;
  logic               din;
  logic [7:0]         bcd_next;
  logic               over_range;
  logic [6:0]         tens_g;
  logic [6:0]         ones_g;
  logic [13:0]        field_glyphs;

  logic [BD_W-1:0]       blink_cnt;
  logic                  hidden;
  logic [NUM_FIELDS-1:0] mask_q;
  logic [SEG_W-1:0]      seg_out;

  // Out-of-range selects simply find no match, which flags the whole frame as dashes.
  always_comb begin
    picked  = '0;
    sel_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        picked  = bus.src_data[k*FRAME_W +: FRAME_W];
        sel_hit = 1'b1;
      end
    end
  end

  always_comb begin
    cur_field = '0;
    for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
      if (fidx == FI_W'(f)) cur_field = snap[f*FIELD_W +: FIELD_W];
    end
    din      = cur_field[BC_W'(FIELD_W-1) - bitcnt];
    bcd_next = dabble_step(bcd, din);
  end

  always_comb begin
    over_range = cur_field > FIELD_W'(99);
    tens_g     = glyph(bcd_next[7:4]);
    ones_g     = glyph(bcd_next[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
    if (fidx == FI_W'(NUM_FIELDS-1) && bcd_next[7:4] == 4'd0) tens_g = GLYPH_OFF;
`endif
    if (sel_bad || over_range) field_glyphs = {GLYPH_DASH, GLYPH_DASH};
    else                       field_glyphs = {tens_g, ones_g};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      snap     <= '0;
      sel_bad  <= 1'b0;
      fidx     <= '0;
      bitcnt   <= '0;
      bcd      <= '0;
      shadow   <= '1;
      seg_reg  <= '1;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          snap     <= picked;
          sel_bad  <= ~sel_hit;
          fidx     <= '0;
          bitcnt   <= '0;
          bcd      <= '0;
          busy_reg <= 1'b1;
          state    <= CONV;
        end
        CONV: begin
          if (bitcnt == BC_W'(FIELD_W-1)) begin
            for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
              if (fidx == FI_W'(f)) shadow[f*14 +: 14] <= field_glyphs;
            end
            bcd    <= '0;
            bitcnt <= '0;
            if (fidx == FI_W'(NUM_FIELDS-1)) state <= UPDATE;
            else                             fidx  <= fidx + FI_W'(1);
          end else begin
            bcd    <= bcd_next;
            bitcnt <= bitcnt + BC_W'(1);
          end
        end
        UPDATE: begin
          seg_reg  <= shadow;
          done_reg <= 1'b1;
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A mask edit restarts the blink period visible so the newly selected field shows at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      hidden    <= 1'b0;
      mask_q    <= '0;
    end else begin
      mask_q <= bus.edit_mask;
      if (bus.edit_mask != mask_q) begin
        blink_cnt <= '0;
        hidden    <= 1'b0;
      end else if (blink_cnt == BD_W'(BLINK_DIV-1)) begin
        blink_cnt <= '0;
        hidden    <= ~hidden;
      end else begin
        blink_cnt <= blink_cnt + BD_W'(1);
      end
    end
  end

  always_comb begin
    seg_out = seg_reg;
    for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
      if (hidden && bus.edit_mask[f]) seg_out[f*14 +: 14] = '1;
    end
  end

  assign bus.seg        = seg_out;
  assign bus.busy       = busy_reg;
  assign bus.frame_done = done_reg;

endmodule

// File: tb/tb_seg7_frame_display.sv
// Scoreboard bench for seg7_frame_display: randomized frames checked against a decimal reference model.
module tb_seg7_frame_display;

  localparam int NS = 3;
  localparam int NF = 3;
  localparam int FW = 8;
  localparam int BD = 4;
  localparam int SW = 2;
  localparam int DW = NS*NF*FW;
  localparam int GW = NF*14;
  localparam int TIMEOUT = 100;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  seg7_frame_display_if #(.NUM_SRC(NS), .NUM_FIELDS(NF), .FIELD_W(FW), .SEL_W(SW)) bus ();

  seg7_frame_display #(
    .NUM_SRC(NS), .NUM_FIELDS(NF), .FIELD_W(FW), .BLINK_DIV(BD), .SEL_W(SW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [GW-1:0] exp_q[$];
  bit sb_on = 1'b1;
  logic [DW-1:0] cur_d;
  int cur_s;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [GW-1:0] expect_frame(input logic [DW-1:0] data, input int s);
    logic [GW-1:0] r;
    logic [6:0] tg;
    int v;
    r = '1;
    for (int f = 0; f < NF; f++) begin
      v = (s < NS) ? int'(data[(s*NF+f)*FW +: FW]) : 1000;
      if (v > 99) begin
        r[f*14 +: 14] = {7'h3F, 7'h3F};
      end else begin
        tg = glyph_of(v / 10);
`ifdef LEADING_ZERO_BLANK_EN
        if (f == NF-1 && v < 10) tg = 7'h7F;
`endif
        r[f*14 +: 14] = {tg, glyph_of(v % 10)};
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    int v;
    for (int k = 0; k < NS*NF; k++) begin
      v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 99);
      d[k*FW +: FW] = FW'(v);
    end
    return d;
  endfunction

  function automatic logic [DW-1:0] set_src(input logic [DW-1:0] base, input int k,
                                             input int h, input int m, input int s);
    logic [DW-1:0] d;
    d = base;
    d[(k*NF+0)*FW +: FW] = FW'(s);
    d[(k*NF+1)*FW +: FW] = FW'(m);
    d[(k*NF+2)*FW +: FW] = FW'(h);
    return d;
  endfunction

  task automatic apply(input logic [DW-1:0] d, input int s);
    cur_d        = d;
    cur_s        = s;
    bus.src_data = d;
    bus.sel      = SW'(s);
    exp_q.push_back(expect_frame(d, s));
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.frame_done && n < TIMEOUT);
    if (!bus.frame_done) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_done_timeout: waited %0d cycles, required a pulse within %0d", n, TIMEOUT);
    end
  endtask

  // Monitor: frame spacing, busy width and scoreboard comparison on every frame_done.
  int gap = 0;
  int busy_cnt = 0;
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        gap      = 0;
        busy_cnt = 0;
      end else begin
        gap++;
        if (bus.busy) busy_cnt++;
        if (bus.frame_done) begin
          if (sb_on) begin
            check("frame_gap", 64'(gap), 64'(NF*FW+2));
            check("busy_cycles", 64'(busy_cnt), 64'(NF*FW+1));
            check("busy_at_done", 64'(bus.busy), 64'(0));
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL scoreboard_underflow: got frame seg %h with no expectation queued", bus.seg);
            end else begin
              check("frame_seg", 64'(bus.seg), 64'(exp_q.pop_front()));
            end
          end
          gap      = 0;
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [GW-1:0] base;
    logic [GW-1:0] e;

    bus.edit_mask = '0;
    d = set_src(rand_data(), 0, 23, 42, 59);
    apply(d, 0);
    repeat (3) @(negedge clock);
    check("reset_seg", 64'(bus.seg), 64'({GW{1'b1}}));
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_frame_done", 64'(bus.frame_done), 64'(0));
    @(negedge clock);
    #2 reset = 1'b1;

    repeat (3) @(negedge clock);
    check("seg_before_first_frame", 64'(bus.seg), 64'({GW{1'b1}}));
    // Each next frame's inputs are changed mid-frame; the running frame must not see them.
    apply(set_src(d, 0, 23, 99, 100), 0);
    wait_fd();
    repeat (3) @(negedge clock);
    d = set_src(cur_d, 1, 0, 0, 0);
    apply(d, 1);
    wait_fd();
    repeat (3) @(negedge clock);
    apply(d, 3);
    wait_fd();
    repeat (3) @(negedge clock);
    apply(set_src(d, 0, 5, 5, 0), 0);
    for (int i = 0; i < 40; i++) begin
      wait_fd();
      repeat (3) @(negedge clock);
      apply(rand_data(), $urandom_range(0, 3));
    end

    wait_fd();
    repeat (10) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midframe_reset_seg", 64'(bus.seg), 64'({GW{1'b1}}));
    check("midframe_reset_busy", 64'(bus.busy), 64'(0));
    exp_q.delete();
    apply(cur_d, cur_s);
    @(negedge clock);
    #2 reset = 1'b1;
    wait_fd();

    sb_on = 1'b0;
    d = set_src(rand_data(), 0, 23, 42, 59);
    bus.src_data = d;
    bus.sel      = '0;
    base = expect_frame(d, 0);
    wait_fd();
    wait_fd();
    @(negedge clock);
    bus.edit_mask = 3'b010;
    for (int k = 0; k < 14; k++) begin
      @(negedge clock);
      e = base;
      if (((k / 4) % 2) == 1) e[14 +: 14] = '1;
      check("blink_m", 64'(bus.seg), 64'(e));
    end
    bus.edit_mask = 3'b100;
    #1;
    e = base;
    e[28 +: 14] = '1;
    check("blink_mask_change_same_cycle", 64'(bus.seg), 64'(e));
    @(negedge clock);
    check("blink_mask_change_visible", 64'(bus.seg), 64'(base));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
